dm_arbiter: RTL

//  Shares the single-port word data memory between two requesters: M0 = CPU data port, M1 = DMA/debug loader.

---
 rtl/dm_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (M0) and DMA/loader (M1).
// Optional burst lock is enabled by defining ARB_BURST_EN.
module dm_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [31:0]       m0_pc,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [31:0]       m1_pc,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic [31:0]       mem_wpc,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam logic [1:0] IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;

  logic [1:0] owner;
  logic       last_winner;  // 1 = M1 won the most recent grant
  logic       hold0, hold1, win1, any_req, sel_we, aligned;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt;
  logic          win_lock, win_owned;

  assign hold0 = (owner == OWN0) && m0_req && m0_lock && (burst_cnt < CW'(MAX_BURST));
  assign hold1 = (owner == OWN1) && m1_req && m1_lock && (burst_cnt < CW'(MAX_BURST));
  assign win_lock  = m0_gnt ? m0_lock : m1_lock;
  assign win_owned = m0_gnt ? (owner == OWN0) : (owner == OWN1);

  // Counts consecutive locked beats by the same owner; restarts on a new owner or after the cap.
  always_ff @(posedge clk) begin
    if (!reset)
      burst_cnt <= '0;
    else if ((m0_gnt || m1_gnt) && win_lock)
      burst_cnt <= (win_owned && burst_cnt < CW'(MAX_BURST)) ? burst_cnt + CW'(1) : CW'(1);
    else
      burst_cnt <= '0;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(MAX_BURST) ^ {30'd0, m0_lock, m1_lock};
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
`endif

  always_comb begin
    win1 = m1_req;
    if (m0_req && m1_req) begin
      if (hold0)      win1 = 1'b0;
      else if (hold1) win1 = 1'b1;
      else            win1 = ~last_winner;
    end
  end

  assign any_req = m0_req | m1_req;
  assign m0_gnt  = reset & any_req & ~win1;
  assign m1_gnt  = reset & any_req & win1;

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_wpc  = '0;
    sel_we   = 1'b0;
    if (m0_gnt) begin
      mem_addr = m0_addr;
      mem_wd   = m0_wdata;
      mem_wpc  = m0_pc;
      sel_we   = m0_we;
    end else if (m1_gnt) begin
      mem_addr = m1_addr;
      mem_wd   = m1_wdata;
      mem_wpc  = m1_pc;
      sel_we   = m1_we;
    end
  end

  assign aligned = (mem_addr[1:0] == 2'b00);
  assign mem_we  = (m0_gnt | m1_gnt) & sel_we & aligned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_winner <= 1'b1;
      owner       <= IDLE;
      m0_rvalid   <= 1'b0;
      m1_rvalid   <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      m0_rvalid <= m0_gnt;
      m1_rvalid <= m1_gnt;
      m0_err    <= m0_gnt & ~aligned;
      m1_err    <= m1_gnt & ~aligned;
      if (m0_gnt && !m0_we && aligned) m0_rdata <= mem_rd;
      if (m1_gnt && !m1_we && aligned) m1_rdata <= mem_rd;
      if (m0_gnt) begin
        last_winner <= 1'b0;
        owner       <= OWN0;
      end else if (m1_gnt) begin
        last_winner <= 1'b1;
        owner       <= OWN1;
      end else begin
        owner <= IDLE;
      end
    end
  end
endmodule
